// File: rtl/reg_writeback.sv
// reg_writeback: register-file write-port producer merging ALU results and buffered load responses.
// Optional load bypass (FIFO empty, no ALU) is enabled by defining WB_BYPASS_EN.
`default_nettype none

module reg_writeback #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3,
   parameter int DEPTH  = 4,
   localparam int NUM_REGS = 2 ** ADDR_W,
   localparam int PTR_W    = $clog2(DEPTH),
   localparam int CNT_W    = PTR_W + 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                alu_valid,
   input  logic [ADDR_W-1:0]   alu_addr,
   input  logic [DATA_W-1:0]   alu_data,
   input  logic                issue_valid,
   input  logic [ADDR_W-1:0]   issue_addr,
   input  logic                ld_valid,
   output logic                ld_ready,
   input  logic [ADDR_W-1:0]   ld_addr,
   input  logic [DATA_W-1:0]   ld_data,
   output logic                rf_we,
   output logic [ADDR_W-1:0]   rf_addr,
   output logic [DATA_W-1:0]   rf_data,
   output logic [NUM_REGS-1:0] pending,
   output logic [CNT_W-1:0]    fifo_count,
   output logic                err_hazard
);

   localparam int ENTRY_W = ADDR_W + DATA_W;

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;

   logic               fifo_empty;
   logic               fifo_full;
   logic               accept;
   logic               push;
   logic               pop;
   logic               bypass;
   logic [ADDR_W-1:0]  head_addr;
   logic [DATA_W-1:0]  head_data;

   logic               sel_valid;
   logic               sel_load;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_data;

   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] clr_mask;
   logic [CNT_W-1:0]    count_next;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CNT_W'(DEPTH));
   assign ld_ready   = ~fifo_full;
   assign accept     = ld_valid & ld_ready;
   assign fifo_count = count;

   assign head_addr = mem[rd_ptr][ENTRY_W-1:DATA_W];
   assign head_data = mem[rd_ptr][DATA_W-1:0];

   // The FIFO only drains when the ALU is not holding the port.
   assign pop = ~alu_valid & ~fifo_empty;

`ifdef WB_BYPASS_EN
   assign bypass = accept & fifo_empty & ~alu_valid;
`else
   assign bypass = 1'b0;
`endif

   assign push = accept & ~bypass;

   always_comb begin
      sel_valid = 1'b0;
      sel_load  = 1'b0;
      sel_addr  = rf_addr;
      sel_data  = rf_data;
      if (alu_valid) begin
         sel_valid = 1'b1;
         sel_addr  = alu_addr;
         sel_data  = alu_data;
      end else if (pop) begin
         sel_valid = 1'b1;
         sel_load  = 1'b1;
         sel_addr  = head_addr;
         sel_data  = head_data;
      end else if (bypass) begin
         sel_valid = 1'b1;
         sel_load  = 1'b1;
         sel_addr  = ld_addr;
         sel_data  = ld_data;
      end
   end

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (issue_valid) set_mask = NUM_REGS'(1) << issue_addr;
      if (sel_load)    clr_mask = NUM_REGS'(1) << sel_addr;
   end

   always_comb begin
      count_next = count;
      if (push && !pop)      count_next = count + CNT_W'(1);
      else if (pop && !push) count_next = count - CNT_W'(1);
   end

   // Storage needs no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {ld_addr, ld_data};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_next;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rf_we   <= 1'b0;
         rf_addr <= '0;
         rf_data <= '0;
      end else begin
         rf_we <= sel_valid;
         if (sel_valid) begin
            rf_addr <= sel_addr;
            rf_data <= sel_data;
         end
      end
   end

   // A new issue to a register wins over a load write retiring the same register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending    <= '0;
         err_hazard <= 1'b0;
      end else begin
         pending <= (pending & ~clr_mask) | set_mask;
         if (alu_valid && pending[alu_addr]) err_hazard <= 1'b1;
      end
   end

endmodule

`default_nettype wire
